hwpe_stream_realign_sequencer: RTL
==================================

# hwpe_stream_realign_sequencer

Per-beat control sequencer for the sink realigner in an HWPE streamer's store path. From a job descriptor (byte base address, words per line, line stride, line count) it produces the `ctrl_realign_t` control word, the strobe mask and the word-aligned memory address for every output beat. It advances one beat per realigner output handshake and inserts one flush beat per line when the base address is misaligned. It sits between the streamer's job-control register file and the sink realigner / TCDM store port.

## Interface
- DATA_WIDTH, 32, stream data width; multiple of 8
- STRB_WIDTH, DATA_WIDTH/8, strobe width; power of two ≥ 2
- ADDR_WIDTH, 32, byte address width
- OFFS_WIDTH, $clog2(STRB_WIDTH), local; width of the byte offset
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear; forces IDLE and the reset values
- start_i  in  1  job start pulse; sampled only in IDLE
- base_addr_i  in  ADDR_WIDTH  byte base address of the job
- line_length_i  in  16  words per line
- line_stride_i  in  ADDR_WIDTH  byte distance between line starts
- n_lines_i  in  16  number of lines
- beat_i  in  1  realigner output beat accepted (pop valid & ready)
- ctrl_o  out  ctrl_realign_t  {enable, strb_valid, realign, first, last, last_packet, line_length}
- strb_o  out  STRB_WIDTH  strobe mask for the realigner's strb input
- addr_o  out  ADDR_WIDTH  word-aligned store address of the current beat
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse at job end

## Operation
- Job registers are latched on start_i in IDLE: base, length, stride, lines, and offs = base_addr_i[OFFS_WIDTH-1:0]. realign_q = (offs != 0).
- FSM states are IDLE, RUN, FLUSH and DONE.
- IDLE, start_i: if line_length_i == 0 or n_lines_i == 0, go to DONE; otherwise go to RUN with word_cnt = 0, line_cnt = 0, line_addr = base with the low OFFS_WIDTH bits cleared.
- RUN, beat_i:
  - If word_cnt < length-1, increment word_cnt.
  - Otherwise, if realign_q, go to FLUSH.
  - Otherwise end the line.
- FLUSH, beat_i: end the line.
- End of line: line_addr += stride and word_cnt = 0. If line_cnt == lines-1, go to DONE; else line_cnt++ and stay in / return to RUN.
- DONE: stay one cycle, then go to IDLE.
- ctrl_o fields:
  - ctrl_o.first = RUN and word_cnt == 0.
  - ctrl_o.last = FLUSH.
  - ctrl_o.last_packet = DONE.
  - ctrl_o.realign = realign_q while busy.
  - ctrl_o.enable = busy_o and ctrl_o.strb_valid = busy_o.
  - ctrl_o.line_length = length.
- strb_o:
  - RUN, word_cnt == 0: ('1 << offs).
  - Other RUN beats: all ones.
  - FLUSH: ~('1 << offs).
  - When aligned: all ones in RUN.
  - IDLE and DONE: 0.
- addr_o = line_addr + (word_cnt << OFFS_WIDTH) in RUN. In FLUSH it is line_addr + (length << OFFS_WIDTH). Otherwise it is 0.
- Arithmetic: addresses wrap modulo 2^ADDR_WIDTH. Counters are 16 bit. The product length << OFFS_WIDTH is computed in ADDR_WIDTH bits and truncated.
- start_i outside IDLE is ignored. beat_i in IDLE or DONE is ignored.
- clear_i or reset mid-job abandons the job immediately: no done_o and no last_packet.

## Timing
- All outputs are Moore-registered state decodes; there is no combinational path from beat_i or start_i to any output.
- Reset/clear values: state IDLE, ctrl_o all 0, strb_o 0, addr_o 0, busy_o 0, done_o 0.
- Start to first beat: start_i in cycle t gives RUN with ctrl_o.first = 1 in cycle t+1.
- Outputs hold while beat_i is low. Each beat_i advances exactly one beat on the next edge.
- A job produces lines × (length + realign_q) beats, then DONE for one cycle, with done_o = 1 and ctrl_o.last_packet = 1 in the same cycle.
- A zero-length job gives done_o at t+1 with no beats.
- busy_o is high from t+1 through DONE inclusive.

## Configuration
- HWPE_STREAM_REALIGN_SEQ_STRIDE_EN defined: line_stride_i is used as described above.
- Not defined: line_stride_i is ignored and lines are contiguous; line_addr += length << OFFS_WIDTH.
- The not-defined behaviour also applies to a misaligned job: the flush beat of line n and the first beat of line n+1 address the same word.

## Structure
- ctrl_realign_t is already in hwpe_stream_package.
- Add to the same package the state enum realign_seq_state_t {IDLE, RUN, FLUSH, DONE}.
- Single module, no sub-modules; the strobe-mask generation is an inline function.

## Test plan
- Aligned job: base 0x100, length 3, lines 1, beat_i always 1.
  - Response: addr 0x100/0x104/0x108 with strb 0xF, first on beat 0, no last, then DONE with last_packet and done_o.
- Misaligned job: base 0x102, length 2, lines 1.
  - Response: strb 0xC, 0xF, then FLUSH strb 0x3 with last = 1 at addr 0x108; 3 beats total.
- 2D stride job: base 0x1001, length 2, stride 0x40, lines 2.
  - Response: line 2 starts at 0x1040 with first = 1; 6 beats total.
- Backpressure: beat_i low for 5 cycles mid-line.
  - Response: addr, strb and ctrl stable throughout; the sequence resumes unchanged.
- Zero-length job (length 0), then start_i pulsed while busy.
  - Response: done_o one cycle after start with no beats; the busy-time start is ignored.
- clear_i during FLUSH.
  - Response: next cycle IDLE, all outputs 0, no done_o; a new job then runs correctly.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// Shared HWPE streamer types: realigner control word and sequencer state.
// Imported by the store-path realign sequencer.
package hwpe_stream_package;

    typedef struct packed {
        logic        enable;
        logic        strb_valid;
        logic        realign;
        logic        first;
        logic        last;
        logic        last_packet;
        logic [15:0] line_length;
    } ctrl_realign_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } realign_seq_state_t;

endpackage

// File: rtl/hwpe_stream_realign_sequencer.sv
// Per-beat control sequencer for the store-path sink realigner.
// In: clk_i, rst_ni, clear_i, start_i, job descriptor, beat_i.
// Out: ctrl_o, strb_o, addr_o (word aligned), busy_o, done_o.
// HWPE_STREAM_REALIGN_SEQ_STRIDE_EN: use line_stride_i between lines;
// otherwise lines are contiguous (line_length words apart).
module hwpe_stream_realign_sequencer
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [15:0]           line_length_i,
    input  logic [ADDR_WIDTH-1:0] line_stride_i,
    input  logic [15:0]           n_lines_i,
    input  logic                  beat_i,
    output ctrl_realign_t         ctrl_o,
    output logic [STRB_WIDTH-1:0] strb_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned OFFS_WIDTH = $clog2(STRB_WIDTH);

    function automatic logic [STRB_WIDTH-1:0] strb_mask(
        input logic [OFFS_WIDTH-1:0] offs
    );
        strb_mask = {STRB_WIDTH{1'b1}} << offs;
    endfunction

    realign_seq_state_t    state_q;
    logic [15:0]           length_q;
    logic [15:0]           lines_q;
    logic [OFFS_WIDTH-1:0] offs_q;
    logic                  realign_q;
    logic [15:0]           word_cnt_q;
    logic [15:0]           line_cnt_q;
    logic [ADDR_WIDTH-1:0] line_addr_q;

    logic [ADDR_WIDTH-1:0] line_bytes;
    logic [ADDR_WIDTH-1:0] line_step;
    logic                  last_word;
    logic                  end_line;

    assign line_bytes = ADDR_WIDTH'(length_q) << OFFS_WIDTH;

`ifdef HWPE_STREAM_REALIGN_SEQ_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q;
    assign line_step = stride_q;
`else
    logic unused_stride;
    assign unused_stride = ^line_stride_i;
    assign line_step     = line_bytes;
`endif

    assign last_word = (word_cnt_q == length_q - 16'd1);

    // A line ends on its last data word when aligned, else on the flush beat.
    always_comb begin
        end_line = 1'b0;
        if (beat_i) begin
            if (state_q == FLUSH)
                end_line = 1'b1;
            else if (state_q == RUN && last_word && !realign_q)
                end_line = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            length_q    <= '0;
            lines_q     <= '0;
            offs_q      <= '0;
            realign_q   <= 1'b0;
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            line_addr_q <= '0;
`ifdef HWPE_STREAM_REALIGN_SEQ_STRIDE_EN
            stride_q    <= '0;
`endif
        end else if (clear_i) begin
            state_q     <= IDLE;
            length_q    <= '0;
            lines_q     <= '0;
            offs_q      <= '0;
            realign_q   <= 1'b0;
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            line_addr_q <= '0;
`ifdef HWPE_STREAM_REALIGN_SEQ_STRIDE_EN
            stride_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        length_q   <= line_length_i;
                        lines_q    <= n_lines_i;
                        offs_q     <= base_addr_i[OFFS_WIDTH-1:0];
                        realign_q  <= (base_addr_i[OFFS_WIDTH-1:0] != '0);
                        word_cnt_q <= '0;
                        line_cnt_q <= '0;
                        line_addr_q <= {base_addr_i[ADDR_WIDTH-1:OFFS_WIDTH],
                                        {OFFS_WIDTH{1'b0}}};
`ifdef HWPE_STREAM_REALIGN_SEQ_STRIDE_EN
                        stride_q   <= line_stride_i;
`endif
                        if (line_length_i == '0 || n_lines_i == '0)
                            state_q <= DONE;
                        else
                            state_q <= RUN;
                    end
                end
                RUN: begin
                    if (beat_i && !last_word)
                        word_cnt_q <= word_cnt_q + 16'd1;
                    else if (beat_i && realign_q)
                        state_q <= FLUSH;
                end
                FLUSH: ;
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (end_line) begin
                line_addr_q <= line_addr_q + line_step;
                word_cnt_q  <= '0;
                if (line_cnt_q == lines_q - 16'd1) begin
                    state_q <= DONE;
                end else begin
                    line_cnt_q <= line_cnt_q + 16'd1;
                    state_q    <= RUN;
                end
            end
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        ctrl_o = '0;
        strb_o = '0;
        addr_o = '0;
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
        if (busy_o) begin
            ctrl_o.enable      = 1'b1;
            ctrl_o.strb_valid  = 1'b1;
            ctrl_o.realign     = realign_q;
            ctrl_o.line_length = length_q;
        end
        case (state_q)
            RUN: begin
                ctrl_o.first = (word_cnt_q == '0);
                strb_o = (word_cnt_q == '0) ? strb_mask(offs_q)
                                            : {STRB_WIDTH{1'b1}};
                addr_o = line_addr_q
                       + (ADDR_WIDTH'(word_cnt_q) << OFFS_WIDTH);
            end
            FLUSH: begin
                ctrl_o.last = 1'b1;
                strb_o = ~strb_mask(offs_q);
                addr_o = line_addr_q + line_bytes;
            end
            DONE: ctrl_o.last_packet = 1'b1;
            default: ;
        endcase
    end

endmodule
